// File: rtl/can_bit_destuffer.sv
// ---------------------------------------------------------------------------
// can_bit_destuffer
//   Receive-side CAN bit destuffer. RX is sampled on every rising SP edge.
//   Inside the stuffed region (F_STF=1) runs of equal bits are tracked, and
//   the bit that follows RUN_LEN equal bits is flagged as a stuff bit and
//   withheld from the data stream. The destuffed stream is presented with
//   a valid strobe and a saturating count of accepted data bits.
//
// Ports
//   SP          in   clock; rising edge is the bit sample point
//   reset       in   synchronous active-high reset
//   RX          in   received bus bit
//   F_STF       in   1 = current bit lies inside the stuffed region
//   DS_BIT      out  registered copy of the last sampled RX
//   DS_VALID    out  1 = DS_BIT is a data bit
//   STUFF_FLAG  out  1 = DS_BIT was a stuff bit (to be dropped)
//   DS_CNT      out  data bits accepted since F_STF rose (saturating)
// ---------------------------------------------------------------------------
module can_bit_destuffer #(
    parameter int RUN_LEN = 5,
    parameter int CNT_W   = 7
) (
    input  logic             SP,
    input  logic             reset,
    input  logic             RX,
    input  logic             F_STF,
    output logic             DS_BIT,
    output logic             DS_VALID,
    output logic             STUFF_FLAG,
    output logic [CNT_W-1:0] DS_CNT
);

    localparam int RUN_W = $clog2(RUN_LEN + 1);

    // Output registers
    logic             r_ds_bit;
    logic             r_ds_valid;
    logic             r_stuff_flag;
    logic [CNT_W-1:0] r_ds_cnt;

    // Run-tracking state
    logic [RUN_W-1:0] r_run;
    logic             r_prev;
    logic             r_first;
    logic             r_stuff_due;

    logic [RUN_W-1:0] w_run_next;
    logic             w_run_full;

    // Counter increment that sticks at the all-ones value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Length of the run after accepting RX as a data bit. A new run starts on
    // the first bit of the region or on a polarity change. r_run cannot
    // exceed RUN_LEN here: reaching RUN_LEN forces the next slot to be a
    // stuff slot, which restarts the run at 1.
    always_comb begin
        w_run_next = RUN_W'(1);
        if (!r_first && (RX == r_prev))
            w_run_next = r_run + RUN_W'(1);
    end

    assign w_run_full = (w_run_next == RUN_W'(RUN_LEN));

    always_ff @(posedge SP) begin
        if (reset) begin
            r_ds_bit     <= 1'b0;
            r_ds_valid   <= 1'b0;
            r_stuff_flag <= 1'b0;
            r_ds_cnt     <= '0;
            r_run        <= '0;
            r_prev       <= 1'b0;
            r_first      <= 1'b1;
            r_stuff_due  <= 1'b0;
        end else if (!F_STF) begin
            // Outside the stuffed region every bit is data; any pending
            // stuff slot is abandoned.
            r_ds_bit     <= RX;
            r_ds_valid   <= 1'b1;
            r_stuff_flag <= 1'b0;
            r_ds_cnt     <= '0;
            r_run        <= '0;
            r_first      <= 1'b1;
            r_stuff_due  <= 1'b0;
        end else if (r_stuff_due) begin
            // Stuff slot: the bit is dropped but opens a new run, even when it
            // has the same polarity as the run it terminates. Flagging that
            // violation is left to the downstream stuff-error checker.
            r_ds_bit     <= RX;
            r_ds_valid   <= 1'b0;
            r_stuff_flag <= 1'b1;
            r_prev       <= RX;
            r_run        <= RUN_W'(1);
            r_first      <= 1'b0;
            r_stuff_due  <= 1'b0;
        end else begin
            r_ds_bit     <= RX;
            r_ds_valid   <= 1'b1;
            r_stuff_flag <= 1'b0;
            r_ds_cnt     <= sat_inc(r_ds_cnt);
            r_prev       <= RX;
            r_run        <= w_run_next;
            r_first      <= 1'b0;
            r_stuff_due  <= w_run_full;
        end
    end

    assign DS_BIT     = r_ds_bit;
    assign DS_VALID   = r_ds_valid;
    assign STUFF_FLAG = r_stuff_flag;
    assign DS_CNT     = r_ds_cnt;

endmodule

// File: tb/tb_can_bit_destuffer.sv
// ---------------------------------------------------------------------------
// tb_can_bit_destuffer
//   Scoreboard bench for can_bit_destuffer. Two instances (CNT_W=7 and
//   CNT_W=3) share the same stimulus so counter saturation is exercised
//   alongside normal operation. The reference model keeps the list of bits
//   received in the current stuffed region and decides stuff slots from the
//   last RUN_LEN entries of that list.
// ---------------------------------------------------------------------------
module tb_can_bit_destuffer;

    localparam int RUN_LEN = 5;

    logic       SP = 1'b0;
    logic       reset = 1'b1;
    logic       RX = 1'b1;
    logic       F_STF = 1'b1;

    logic       b7, v7, s7;
    logic [6:0] c7;
    logic       b3, v3, s3;
    logic [2:0] c3;

    always #5 SP = ~SP;

    can_bit_destuffer #(.RUN_LEN(RUN_LEN), .CNT_W(7)) u_dut7 (
        .SP(SP), .reset(reset), .RX(RX), .F_STF(F_STF),
        .DS_BIT(b7), .DS_VALID(v7), .STUFF_FLAG(s7), .DS_CNT(c7)
    );

    can_bit_destuffer #(.RUN_LEN(RUN_LEN), .CNT_W(3)) u_dut3 (
        .SP(SP), .reset(reset), .RX(RX), .F_STF(F_STF),
        .DS_BIT(b3), .DS_VALID(v3), .STUFF_FLAG(s3), .DS_CNT(c3)
    );

    typedef struct {
        logic b;
        logic v;
        logic s;
        int   cnt;
    } exp_t;

    typedef struct {
        logic b;
        logic s;
    } ent_t;

    exp_t sbq[$];
    ent_t region[$];
    int   data_cnt = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // The next bit is a stuff slot when the last RUN_LEN bits of the region
    // share one polarity and form a single run: only the oldest of them may
    // itself be a stuff bit (a stuff bit always begins a run).
    function automatic bit stuff_next();
        int n;
        n = region.size();
        if (n < RUN_LEN) return 1'b0;
        for (int k = 0; k < RUN_LEN; k++) begin
            if (region[n-1-k].b != region[n-1].b) return 1'b0;
            if (k < RUN_LEN - 1 && region[n-1-k].s) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic step(input logic r, input logic rx, input logic f);
        exp_t e;
        ent_t t;
        @(negedge SP);
        reset = r;
        RX    = rx;
        F_STF = f;
        @(posedge SP);
        if (r) begin
            e = '{b: 1'b0, v: 1'b0, s: 1'b0, cnt: 0};
            region.delete();
            data_cnt = 0;
        end else if (!f) begin
            e = '{b: rx, v: 1'b1, s: 1'b0, cnt: 0};
            region.delete();
            data_cnt = 0;
        end else if (stuff_next()) begin
            t = '{b: rx, s: 1'b1};
            region.push_back(t);
            e = '{b: rx, v: 1'b0, s: 1'b1, cnt: data_cnt};
        end else begin
            t = '{b: rx, s: 1'b0};
            region.push_back(t);
            data_cnt++;
            e = '{b: rx, v: 1'b1, s: 1'b0, cnt: data_cnt};
        end
        sbq.push_back(e);
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n, input logic f);
        for (int i = n - 1; i >= 0; i--) step(1'b0, bits[i], f);
    endtask

    // Monitor: registered outputs are stable at the falling edge.
    always @(negedge SP) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("ds_bit",     {31'd0, b7}, {31'd0, e.b});
            check("ds_valid",   {31'd0, v7}, {31'd0, e.v});
            check("stuff_flag", {31'd0, s7}, {31'd0, e.s});
            check("ds_cnt_w7",  {25'd0, c7}, sat(e.cnt, 127));
            check("stuff_w3",   {31'd0, s3}, {31'd0, e.s});
            check("ds_cnt_w3",  {29'd0, c3}, sat(e.cnt, 7));
        end
    end

    initial begin
        logic cur;
        logic f;
        // Reset held with active inputs, then first bit after release.
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // Five zeros, stuff, then data.
        send_bits(32'b0000011, 7, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        // Stuff bit starting the next run.
        send_bits(32'b0000011111, 10, 1'b1);
        send_bits(32'b01, 2, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        // Same-polarity stuff bit (violation) restarts the run.
        send_bits(32'b11111111111, 11, 1'b1);
        send_bits(32'b0, 1, 1'b1);
        // Unstuffed region, then entry with a run starting at 1.
        send_bits(32'hFF, 8, 1'b0);
        send_bits(32'b111111, 6, 1'b1);
        // Stuff pending when F_STF drops.
        send_bits(32'b00000, 5, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        send_bits(32'b0000, 4, 1'b1);
        // Reset mid-run, then two more equal bits.
        step(1'b1, 1'b0, 1'b1);
        send_bits(32'b00, 2, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        // Long alternating stream saturates the narrow counter.
        send_bits(32'hAAAAAAAA, 32, 1'b1);

        // Random frames biased towards long runs.
        cur = 1'b0;
        f   = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(99) < 30) cur = ~cur;
            if ($urandom_range(199) == 0) f = ~f;
            if ($urandom_range(499) == 0)
                step(1'b1, cur, f);
            else
                step(1'b0, cur, f);
        end

        repeat (4) @(negedge SP);
        check("queue_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
